seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
// Multi-cycle, width-parametrised ALU for the datapath; next generation of the combinational ALU.
// Performs single-cycle logic, arithmetic, shift and rotate ops, with iterative signed multiply and divide.
// Operands are latched on a start/done handshake. Sits between the A/B operand registers and the Z (HI/LO) register pair.
// Shift and rotate amounts come from B; the old single-position shifts are not used.
// PARAMETERS
// WIDTH   32   operand width; even, >= 4.
// SH_W    $clog2(WIDTH)   shift-amount width (localparam, derived).
// PORTS
// clk         in   1        clock, rising edge
// clr         in   1        synchronous, active-high reset
// start       in   1        request; accepted only when busy=0
// op          in   4        opcode, sampled at accept
// a           in   WIDTH    operand A, sampled at accept
// b           in   WIDTH    operand B, sampled at accept
// busy        out  1        high from the cycle after accept until done
// done        out  1        one-cycle pulse; result is valid from this cycle
// result      out  2*WIDTH  {HI,LO}; held until the next accept
// zero        out  1        result == 0, updated together with done
// div_zero    out  1        last DIV had b==0
// illegal_op  out  1        last op was unsupported
// BEHAVIOUR
// - Reset (clr at posedge): state=IDLE; busy, done, zero, div_zero and illegal_op = 0; result = 0.
// - clr mid-operation aborts; no done pulse follows.
// - Accept: start && !busy && !clr. Latch op, a, b. start while busy is ignored.
//   a and b may change freely after accept.
// - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NEG(a), 5 NOT(a), 6 SRA, 7 MUL, 8 SHL, 9 SHR,
//   A DIV, B ROL, C ROR, D-F illegal.
// - Shift and rotate amount is b[SH_W-1:0]. An amount of 0 passes a through.
// - Single-width ops: LO = result, HI = 0. ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
// - MUL: signed x signed, radix-2 Booth, WIDTH iterations. result = full 2*WIDTH signed product.
// - DIV: signed, quotient truncated toward zero. Remainder takes the sign of the dividend.
//   Restoring division on magnitudes, then one sign-fix cycle. HI = remainder, LO = quotient.
//   MIN / -1 gives quotient = MIN, remainder = 0.
// - DIV with b==0: no iteration. div_zero=1, LO = all ones, HI = a.
// - Illegal op: result = 0, illegal_op = 1, zero = 1.
// - div_zero and illegal_op are updated at every done; they are cleared by a non-faulting op.
// - FSM states: IDLE, EXEC, MUL, DIV, FIX.
//   IDLE --accept--> EXEC (single-cycle ops, illegal op, div by zero) | MUL | DIV
//   EXEC -> IDLE, asserting done
//   MUL --after WIDTH iterations--> IDLE, asserting done
//   DIV --after WIDTH iterations--> FIX -> IDLE, asserting done
// - Latency, with the accept edge as cycle 0 and done high during cycle N:
//   single-cycle ops N=1; MUL N=WIDTH+1; DIV N=WIDTH+2; DIV by zero N=1.
// - busy is high in cycles 1..N-1 and low in the done cycle. A new start may be accepted in the done cycle.
// - zero tests all 2*WIDTH result bits.
// CONFIGURATION
// SEQ_ALU_DIV_EN defined: DIV is supported as described above.
// SEQ_ALU_DIV_EN undefined: the divider and FIX state are not built.
//   Opcode A is treated as illegal (N=1, result 0, illegal_op=1); div_zero is tied to 0.
// TESTING (WIDTH=32)
// 1. ADD a=5, b=7 -> done at cycle 1, result=0x0_0000000C, zero=0; SUB a=7, b=7 -> zero=1.
// 2. MUL a=0xFFFFFFFD (-3), b=7 -> busy cycles 1-32, done at cycle 33, result=0xFFFFFFFF_FFFFFFEB.
// 3. DIV a=-17, b=5 -> done at cycle 34, result={0xFFFFFFFE, 0xFFFFFFFD}. MIN / -1 -> {0, 0x80000000}.
// 4. DIV a=9, b=0 -> done at cycle 1, div_zero=1, result={0x00000009, 0xFFFFFFFF}.
//    Without SEQ_ALU_DIV_EN -> illegal_op=1, result=0.
// 5. a=0x80000001, b=4: ROR -> LO=0x18000000; ROL -> 0x00000018; SRA -> 0xF8000000; SHR -> 0x08000000.
// 6. MUL started, clr at cycle 10 -> busy=0 and result=0 next cycle, no done pulse.
//    start pulses during busy are ignored; op D -> illegal_op=1.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/rotate, Booth signed multiply, restoring signed divide.
// Optional divider built only when SEQ_ALU_DIV_EN is defined; otherwise opcode A is illegal.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               div_zero,
  output logic               illegal_op
);
  localparam int SH_W = $clog2(WIDTH);

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
`endif

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_NEG = 4'h4, OP_NOT = 4'h5, OP_SRA = 4'h6, OP_MUL = 4'h7,
    OP_SHL = 4'h8, OP_SHR = 4'h9, OP_DIV = 4'hA, OP_ROL = 4'hB,
    OP_ROR = 4'hC
  } op_t;

  state_t            state;
  logic [WIDTH:0]    hi;
  logic [WIDTH-1:0]  lo;
  logic              qm1;
  logic [WIDTH-1:0]  mcand;
  logic [SH_W-1:0]   cnt;
  logic              last_iter;

  logic [SH_W-1:0]   amt;
  logic [WIDTH-1:0]  single_res;
  logic              single_ok;

  logic [WIDTH:0]    m_ext;
  logic [WIDTH:0]    acc;
  logic [WIDTH:0]    booth_hi;
  logic [WIDTH-1:0]  booth_lo;
  logic [2*WIDTH-1:0] product;

  assign amt       = b[SH_W-1:0];
  assign last_iter = (cnt == SH_W'(WIDTH - 1));

  always_comb begin
    single_res = '0;
    single_ok  = 1'b1;
    case (op)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_NEG:  single_res = -a;
      OP_NOT:  single_res = ~a;
      OP_SRA:  single_res = $unsigned($signed(a) >>> amt);
      OP_SHL:  single_res = a << amt;
      OP_SHR:  single_res = a >> amt;
      // a shift by WIDTH yields zero, so an amount of 0 passes a through
      OP_ROL:  single_res = (a << amt) | (a >> (WIDTH - int'(amt)));
      OP_ROR:  single_res = (a >> amt) | (a << (WIDTH - int'(amt)));
      default: single_ok = 1'b0;
    endcase
  end

  // Booth step on {hi, lo, qm1}; hi carries one guard bit so subtracting MIN cannot overflow
  always_comb begin
    m_ext = {mcand[WIDTH-1], mcand};
    case ({lo[0], qm1})
      2'b01:   acc = hi + m_ext;
      2'b10:   acc = hi - m_ext;
      default: acc = hi;
    endcase
    booth_hi = {acc[WIDTH], acc[WIDTH:1]};
    booth_lo = {acc[0], lo[WIDTH-1:1]};
    product  = {booth_hi[WIDTH-1:0], booth_lo};
  end

`ifdef SEQ_ALU_DIV_EN
  logic              neg_q;
  logic              neg_r;
  logic              div_zero_r;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    div_hi;
  logic [WIDTH-1:0]  div_lo;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;

  // restoring step: hi holds the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    rem_sh = {hi[WIDTH-1:0], lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, mcand};
    div_hi = trial[WIDTH] ? rem_sh : trial;
    div_lo = {lo[WIDTH-2:0], ~trial[WIDTH]};
    quo    = neg_q ? -lo : lo;
    rem    = neg_r ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
  end

  assign div_zero = div_zero_r;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      qm1        <= 1'b0;
      mcand      <= '0;
      cnt        <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_zero_r <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_EXEC: begin
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            if (op == OP_MUL) begin
              state <= S_MUL;
              busy  <= 1'b1;
              hi    <= '0;
              lo    <= a;
              qm1   <= 1'b0;
              mcand <= b;
              cnt   <= '0;
`ifdef SEQ_ALU_DIV_EN
            end else if (op == OP_DIV && b == '0) begin
              state      <= S_EXEC;
              done       <= 1'b1;
              result     <= {a, {WIDTH{1'b1}}};
              zero       <= 1'b0;
              div_zero_r <= 1'b1;
              illegal_op <= 1'b0;
            end else if (op == OP_DIV) begin
              state <= S_DIV;
              busy  <= 1'b1;
              hi    <= '0;
              lo    <= a_mag;
              mcand <= b_mag;
              neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r <= a[WIDTH-1];
              cnt   <= '0;
`endif
            end else begin
              state      <= S_EXEC;
              done       <= 1'b1;
              result     <= single_ok ? {{WIDTH{1'b0}}, single_res} : '0;
              zero       <= single_ok ? (single_res == '0) : 1'b1;
              illegal_op <= ~single_ok;
`ifdef SEQ_ALU_DIV_EN
              div_zero_r <= 1'b0;
`endif
            end
          end
        end
        S_MUL: begin
          hi  <= booth_hi;
          lo  <= booth_lo;
          qm1 <= lo[0];
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            result     <= product;
            zero       <= (product == '0);
            illegal_op <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_zero_r <= 1'b0;
`endif
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          hi  <= div_hi;
          lo  <= div_lo;
          cnt <= cnt + 1'b1;
          if (last_iter) state <= S_FIX;
        end
        S_FIX: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          done       <= 1'b1;
          result     <= {rem, quo};
          zero       <= ({rem, quo} == '0);
          illegal_op <= 1'b0;
          div_zero_r <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed and random ops against a behavioural model.
// Expectations for opcode A follow SEQ_ALU_DIV_EN in the same way as the design.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        zero;
  logic        div_zero;
  logic        illegal_op;

  int tests = 0;
  int fails = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .div_zero(div_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference computed from the arithmetic definitions, not from the datapath structure
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] r, output logic z, output logic dz,
                                output logic il, output int lat);
    longint      sx;
    longint      sy;
    logic [31:0] t;
    int          n;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    n  = int'(y[4:0]);
    t  = x;
    r  = 64'h0;
    dz = 1'b0;
    il = 1'b0;
    lat = 1;
    case (o)
      4'h0: r = {32'h0, x + y};
      4'h1: r = {32'h0, x - y};
      4'h2: r = {32'h0, x & y};
      4'h3: r = {32'h0, x | y};
      4'h4: r = {32'h0, 32'h0 - x};
      4'h5: r = {32'h0, ~x};
      4'h6: begin repeat (n) t = {t[31], t[31:1]}; r = {32'h0, t}; end
      4'h7: begin r = sx * sy; lat = 33; end
      4'h8: begin repeat (n) t = {t[30:0], 1'b0}; r = {32'h0, t}; end
      4'h9: begin repeat (n) t = {1'b0, t[31:1]}; r = {32'h0, t}; end
`ifdef SEQ_ALU_DIV_EN
      4'hA: begin
        if (y == 32'h0) begin
          r  = {x, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else begin
          r   = {32'(sx % sy), 32'(sx / sy)};
          lat = 34;
        end
      end
`endif
      4'hB: begin repeat (n) t = {t[30:0], t[31]}; r = {32'h0, t}; end
      4'hC: begin repeat (n) t = {t[0], t[31:1]}; r = {32'h0, t}; end
      default: il = 1'b1;
    endcase
    z = (r == 64'h0);
  endfunction

  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    logic [63:0] er;
    logic        ez;
    logic        edz;
    logic        eil;
    int          el;
    int          cyc;
    model(o, x, y, er, ez, edz, eil, el);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      chk($sformatf("busy_op%0h_c%0d", o, cyc), {63'h0, busy}, 64'd1);
      if (poke && cyc == 5) begin start = 1'b1; op = 4'h0; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk($sformatf("latency_op%0h", o), 64'(cyc), 64'(el));
    chk($sformatf("busy_at_done_op%0h", o), {63'h0, busy}, 64'd0);
    chk($sformatf("result_op%0h_%h_%h", o, x, y), result, er);
    chk($sformatf("zero_op%0h", o), {63'h0, zero}, {63'h0, ez});
    chk($sformatf("div_zero_op%0h", o), {63'h0, div_zero}, {63'h0, edz});
    chk($sformatf("illegal_op%0h", o), {63'h0, illegal_op}, {63'h0, eil});
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pulses;
    clr = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_done", {63'h0, done}, 64'd0);
    chk("rst_result", result, 64'h0);
    chk("rst_zero", {63'h0, zero}, 64'd0);
    chk("rst_div_zero", {63'h0, div_zero}, 64'd0);
    chk("rst_illegal", {63'h0, illegal_op}, 64'd0);
    clr = 1'b0;

    run(4'h0, 32'd5, 32'd7, 1'b0);
    run(4'h1, 32'd7, 32'd7, 1'b0);
    run(4'h7, 32'hFFFF_FFFD, 32'd7, 1'b1);
    run(4'hA, 32'hFFFF_FFEF, 32'd5, 1'b1);
    run(4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(4'hA, 32'd9, 32'd0, 1'b0);
    run(4'hA, 32'd17, 32'hFFFF_FFFB, 1'b0);
    run(4'hC, 32'h8000_0001, 32'd4, 1'b0);
    run(4'hB, 32'h8000_0001, 32'd4, 1'b0);
    run(4'h6, 32'h8000_0001, 32'd4, 1'b0);
    run(4'h9, 32'h8000_0001, 32'd4, 1'b0);
    run(4'h8, 32'h8000_0001, 32'd4, 1'b0);
    run(4'hB, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0);
    run(4'hC, 32'h1234_5678, 32'd31, 1'b0);
    run(4'hD, 32'h1111_1111, 32'd2, 1'b0);
    run(4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    run(4'h3, 32'h0, 32'h0, 1'b0);
    run(4'h4, 32'h8000_0000, 32'd0, 1'b0);
    run(4'h5, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(4'h7, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run(4'h7, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    run(4'h7, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run(4'h0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(posedge clk); #1;
    chk("done_single_pulse", {63'h0, done}, 64'd0);

    run(4'h0, 32'h1234, 32'd1, 1'b0);
    op = 4'h7; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("abort_busy_before", {63'h0, busy}, 64'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("abort_busy", {63'h0, busy}, 64'd0);
    chk("abort_result", result, 64'h0);
    chk("abort_done", {63'h0, done}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(0, 40)) - 32'd20;
        default: ;
      endcase
      run(ro, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
